// File: rtl/instr_mem_arbiter.sv
// instr_mem_arbiter: round-robin share of one instruction-memory port between fetch (m0) and trace (m1)
module instr_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CW-1:0]         outstanding,
  output logic                  proto_err
);
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic locked_q, locked_d, locked_owner_q, locked_owner_d;
  logic last_owner_q, last_owner_d, proto_err_q, proto_err_d;
  logic sel, push, pop, head;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // selection, memory request and response routing
  always_comb begin
    sel = locked_q ? locked_owner_q : (m0_req & m1_req) ? ~last_owner_q : m1_req;
    mem_req = (sel ? m1_req : m0_req) & (cnt_q != CW'(MAX_OUTSTANDING)) & ~rst;
    mem_addr = sel ? m1_addr : m0_addr;
    push = mem_req & mem_gnt;
    pop = mem_rvalid & (cnt_q != '0);
    head = fifo_q[rd_ptr_q];
    m0_gnt = push & ~sel;
    m1_gnt = push & sel;
    m0_rvalid = pop & ~head & ~rst;
    m1_rvalid = pop & head & ~rst;
    m0_rdata = mem_rdata;
    m1_rdata = mem_rdata;
    outstanding = cnt_q;
    proto_err = proto_err_q;
  end

  // owner fifo, lock and fairness next state
  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = sel;
    wr_ptr_d = push ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? inc(rd_ptr_q) : rd_ptr_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    locked_d = mem_req & ~mem_gnt;
    locked_owner_d = sel;
    last_owner_d = push ? sel : last_owner_q;
    proto_err_d = proto_err_q | (mem_rvalid & (cnt_q == '0));
  end

  // state registers; last_owner resets to 1 so m0 wins the first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      locked_q <= 1'b0;
      locked_owner_q <= 1'b0;
      last_owner_q <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      fifo_q <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      locked_q <= locked_d;
      locked_owner_q <= locked_owner_d;
      last_owner_q <= last_owner_d;
      proto_err_q <= proto_err_d;
    end
  end
endmodule

// File: doc/instr_mem_arbiter.md
Name: instr_mem_arbiter

Overview:
- Shares one instruction-memory port (req/gnt/rvalid protocol) between two requesters:
  - port 0 is core instruction fetch;
  - port 1 is the trace/debug instruction reader.
- Arbitrates requests round-robin and tracks outstanding transactions in an in-order owner FIFO.
- Routes each rvalid back to the requester that issued it.
- Sits between the core fetch interface and instruction memory, upstream of the memory monitor tap on the mem_* side.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, read data width of all ports
MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
m0_req  input  1  requester 0 request
m0_addr  input  ADDR_WIDTH  requester 0 address
m0_gnt  output  1  requester 0 grant
m0_rvalid  output  1  requester 0 response valid
m0_rdata  output  DATA_WIDTH  requester 0 response data
m1_req  input  1  requester 1 request
m1_addr  input  ADDR_WIDTH  requester 1 address
m1_gnt  output  1  requester 1 grant
m1_rvalid  output  1  requester 1 response valid
m1_rdata  output  DATA_WIDTH  requester 1 response data
mem_req  output  1  memory request
mem_addr  output  ADDR_WIDTH  memory address
mem_gnt  input  1  memory grant
mem_rvalid  input  1  memory response valid
mem_rdata  input  DATA_WIDTH  memory response data
outstanding  output  $clog2(MAX_OUTSTANDING+1)  in-flight transaction count
proto_err  output  1  sticky: rvalid received with no outstanding transaction

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst is synchronous, active-high, sampled on the rising clk edge.
- Reset:
  - Clears owner FIFO, outstanding (0), lock state, proto_err (0); sets last_owner=1 so m0 wins the first contention.
  - While rst is high, mem_req, m0_gnt, m1_gnt, m0_rvalid and m1_rvalid are forced 0.
- Selection (combinational, zero-latency):
  - If locked: sel = locked_owner.
  - Else, only one req high: sel = that requester.
  - Else, both high: sel = !last_owner.
  - Else: no selection.
- Request path:
  - mem_req = req of sel, AND outstanding < MAX_OUTSTANDING, AND !rst.
  - mem_addr = addr of sel; equals m0_addr when nothing is selected.
- Grant path:
  - mX_gnt = mem_gnt & mem_req & (sel==X).
  - The non-selected requester never sees gnt.
- Lock:
  - Set when mem_req=1 and mem_gnt=0; locked_owner = sel.
  - Cleared on the cycle mem_req & mem_gnt.
  - Guarantees address stability until grant; the other requester cannot preempt.
  - If the locked requester drops req (protocol violation by requester), lock clears next cycle.
- last_owner: updated to sel on each mem_req & mem_gnt.
- Owner FIFO:
  - Depth MAX_OUTSTANDING, 1-bit entries.
  - Push sel on mem_req & mem_gnt; pop on mem_rvalid.
  - Pointers wrap modulo depth.
  - outstanding = occupancy; +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Response routing:
  - mX_rvalid = mem_rvalid & (fifo_head==X) & (outstanding!=0).
  - m0_rdata = m1_rdata = mem_rdata (unqualified broadcast).
  - Responses are in order; an rvalid in the same cycle as a grant belongs to an earlier transaction, never the one just granted.
- Full: when outstanding == MAX_OUTSTANDING, mem_req=0 even if mem_rvalid=1 that cycle (conservative); the request is re-presented next cycle.
- Empty: mem_rvalid with outstanding==0 sets proto_err=1 (sticky until rst); no rvalid is forwarded and the FIFO is unchanged.
- Reset mid-transaction:
  - In-flight owners are discarded.
  - The memory must be reset together with this block.
  - Any stale rvalid arriving afterwards raises proto_err.

Test Plan:
- Single requester: m0_req=1, addr=0x100, mem_gnt=1, rvalid one cycle later with rdata=0xDEADBEEF -> m0_gnt same cycle as mem_gnt; m0_rvalid=1 with rdata 0xDEADBEEF; m1_rvalid stays 0; outstanding goes 0->1->0.
- Contention after reset: m0_req and m1_req both high, mem_gnt=1 for 4 cycles -> grants m0,m1,m0,m1; FIFO order 0,1,0,1; four rvalids are routed to m0,m1,m0,m1 in that order.
- Lock: m1 selected, mem_gnt=0 for 3 cycles while m0_req rises -> mem_addr stays m1_addr, m0_gnt=0 throughout; when mem_gnt=1, m1 is granted and m0 is granted on the next cycle.
- Full with MAX_OUTSTANDING=4: 4 grants with no rvalid -> outstanding=4 and mem_req=0. One rvalid -> mem_req stays 0 that cycle; next cycle outstanding=3 and mem_req=1.
- Simultaneous push/pop: grant to m1 in the same cycle as rvalid for an earlier m0 transaction -> m0_rvalid=1, outstanding unchanged, m1 entry at FIFO tail.
- Error and reset: mem_rvalid with outstanding=0 -> proto_err=1, no mX_rvalid. Then rst with 2 outstanding -> outstanding=0, proto_err=0, next contention grants m0.
